// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller beside ID: a shift-register scoreboard of in-flight
// destinations drives stall, ID-stage bypass selects and registered EX bypass selects.
module pipe_hazard_unit #(
   parameter int NSTAGE   = 3,
   parameter int RA_W     = 5,
   parameter int ALU_LAT  = 1,
   parameter int LOAD_LAT = 2,
   parameter int CNT_W    = 16,
   localparam int FW      = $clog2(NSTAGE + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [RA_W-1:0]  i_id_rs,
   input  logic [RA_W-1:0]  i_id_rt,
   input  logic             i_id_rs_used,
   input  logic             i_id_rt_used,
   input  logic             i_id_branch,
   input  logic             i_id_wr_en,
   input  logic [RA_W-1:0]  i_id_wr_addr,
   input  logic             i_id_is_load,
   input  logic             i_id_flush,
   output logic             o_stall,
   output logic [FW-1:0]    o_id_fwd_a,
   output logic [FW-1:0]    o_id_fwd_b,
   output logic [FW-1:0]    o_ex_fwd_a,
   output logic [FW-1:0]    o_ex_fwd_b,
   output logic [CNT_W-1:0] o_stall_cnt
);

   // Scoreboard slot k holds the producer currently in post-ID stage k (1=EX).
   logic            r_v    [1:NSTAGE];
   logic [RA_W-1:0] r_addr [1:NSTAGE];
   logic [FW-1:0]   r_lat  [1:NSTAGE];
   logic [FW-1:0]   r_ex_fwd_a;
   logic [FW-1:0]   r_ex_fwd_b;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [RA_W-1:0] w_src  [2];
   logic            w_used [2];
   int              w_k    [2];
   int              w_lat  [2];
   logic            w_haz  [2];
   logic [FW-1:0]   w_idf  [2];
   logic [FW-1:0]   w_exf  [2];
   logic            w_stall;
   logic            w_ins;
   logic            w_ex_kill;

   always_comb begin
      w_src[0]  = i_id_rs;
      w_src[1]  = i_id_rt;
      w_used[0] = i_id_rs_used;
      w_used[1] = i_id_rt_used;
      for (int i = 0; i < 2; i++) begin
         w_k[i]   = 0;
         w_lat[i] = 0;
         w_haz[i] = 1'b0;
         w_idf[i] = '0;
         w_exf[i] = '0;
         // Scan oldest to youngest so the youngest match is the one left standing.
         for (int k = NSTAGE; k >= 1; k--) begin
            if (w_used[i] && (w_src[i] != '0) && r_v[k] && (r_addr[k] == w_src[i])) begin
               w_k[i]   = k;
               w_lat[i] = int'(r_lat[k]);
            end
         end
         if (w_k[i] != 0) begin
            w_haz[i] = i_id_branch ? (w_k[i] <= w_lat[i]) : (w_k[i] + 1 <= w_lat[i]);
            if (w_k[i] > w_lat[i])
               w_idf[i] = FW'(w_k[i]);
            if ((w_k[i] + 1 > w_lat[i]) && (w_k[i] + 1 <= NSTAGE))
               w_exf[i] = FW'(w_k[i] + 1);
         end
      end
   end

   assign w_stall   = i_id_valid & ~i_id_flush & (w_haz[0] | w_haz[1]);
   assign w_ins     = i_id_valid & i_id_wr_en & (i_id_wr_addr != '0) & ~w_stall & ~i_id_flush;
   assign w_ex_kill = w_stall | i_id_flush | ~i_id_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            r_v[k]    <= 1'b0;
            r_addr[k] <= '0;
            r_lat[k]  <= '0;
         end
         r_ex_fwd_a  <= '0;
         r_ex_fwd_b  <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int k = NSTAGE; k >= 2; k--) begin
            r_v[k]    <= r_v[k-1];
            r_addr[k] <= r_addr[k-1];
            r_lat[k]  <= r_lat[k-1];
         end
         r_v[1]    <= w_ins;
         r_addr[1] <= i_id_wr_addr;
         r_lat[1]  <= i_id_is_load ? FW'(LOAD_LAT) : FW'(ALU_LAT);
         r_ex_fwd_a <= w_ex_kill ? '0 : w_exf[0];
         r_ex_fwd_b <= w_ex_kill ? '0 : w_exf[1];
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_stall     = w_stall;
   assign o_id_fwd_a  = w_idf[0];
   assign o_id_fwd_b  = w_idf[1];
   assign o_ex_fwd_a  = r_ex_fwd_a;
   assign o_ex_fwd_b  = r_ex_fwd_b;
   assign o_stall_cnt = r_stall_cnt;

endmodule
